frac_divider: RTL and testbench
===============================

FRAC_DIVIDER -- requirements
Module: frac_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 10, unsigned dividend width.
REQ-002 Parameter DIVISOR_W, default 3, unsigned divisor width.
REQ-003 Parameter FRAC_W, default 10, fractional quotient bits; QUO_W = DIVIDEND_W+FRAC_W is derived.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair valid.
REQ-007 in_ready  out  1  block can accept operands.
REQ-008 in_dividend  in  DIVIDEND_W  unsigned dividend.
REQ-009 in_divisor  in  DIVISOR_W  unsigned divisor.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out_quotient  out  QUO_W  floor(dividend*2^FRAC_W/divisor).
REQ-013 out_remainder  out  DIVISOR_W  (dividend*2^FRAC_W) mod divisor.
REQ-014 out_dbz  out  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-015 The FSM SHALL have states IDLE, DIVIDE, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; input accepted on an edge where in_valid && in_ready.
REQ-017 On accept with divisor != 0: latch operands, set numerator = {dividend, FRAC_W zeros}, clear partial remainder and quotient, go to DIVIDE.
REQ-018 On accept with divisor == 0: go directly to DONE with out_quotient all ones, out_remainder 0, out_dbz 1.
REQ-019 DIVIDE SHALL resolve one quotient bit per cycle, MSB first, restoring: shift next numerator bit into the remainder; if remainder >= divisor, subtract and set the bit, else clear it.
REQ-020 The partial remainder SHALL be DIVISOR_W+1 bits wide; no truncation of any intermediate.
REQ-021 After the last quotient bit, go to DONE; without early termination, accept-to-out_valid latency SHALL be exactly QUO_W+1 cycles.
REQ-022 In DONE out_valid SHALL be 1 and out_quotient/out_remainder/out_dbz SHALL be held stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready, return to IDLE (in_ready 1 next cycle); no new accept in the same cycle.
REQ-024 in_valid/operand changes while not in IDLE SHALL be ignored.
REQ-025 out_ready held high before DONE SHALL have no effect.
REQ-026 Maximum operands (all ones / 1) SHALL produce quotient (2^DIVIDEND_W-1)*2^FRAC_W without overflow.

Reset
REQ-027 rst SHALL immediately force IDLE, in_ready 1 after release, out_valid 0, out_quotient 0, out_remainder 0, out_dbz 0.
REQ-028 rst asserted mid-DIVIDE or in DONE SHALL discard the operation; no result emitted after release.

Configuration
REQ-029 Macro FRAC_DIVIDER_EARLY_TERM_EN defined: in DIVIDE, when the partial remainder is 0 and all unconsumed numerator bits are 0, remaining quotient bits SHALL be cleared and the FSM SHALL go to DONE on the next edge.
REQ-030 Macro undefined: DIVIDE SHALL always take exactly QUO_W cycles; results SHALL be bit-identical in both builds.

Verification (default parameters)
REQ-031 Accept 10/3, out_ready=1 -> out_quotient 3413, out_remainder 1, out_dbz 0, out_valid 21 cycles after accept.
REQ-032 Accept 6/3 with FRAC_DIVIDER_EARLY_TERM_EN -> out_quotient 2048, remainder 0, out_valid 10 cycles after accept (21 without macro).
REQ-033 Accept 1023/7 -> out_quotient 149650, out_remainder 2; 1023/1 -> 1047552, remainder 0.
REQ-034 Accept 5/0 -> out_valid next cycle, out_quotient 20'hFFFFF, remainder 0, out_dbz 1.
REQ-035 Hold out_ready 0 for 5 cycles in DONE, toggle in_valid/operands -> outputs stable, in_ready 0, exactly one result accepted when out_ready rises.
REQ-036 Assert rst for 1 cycle at DIVIDE cycle 8 of 10/3 -> all outputs 0, in_ready 1, no out_valid until a new accept.

Source files
------------

// File: rtl/frac_divider.sv
// -----------------------------------------------------------------------------
// frac_divider
//
// Fixed-point unsigned divider. It computes
//   out_quotient  = floor(dividend * 2^FRAC_W / divisor)
//   out_remainder = (dividend * 2^FRAC_W) mod divisor
// using a restoring, bit-serial algorithm that resolves one quotient bit per
// cycle, MSB first.
//
// Protocol:
//   - An operand pair is accepted on a rising edge where in_valid && in_ready.
//     in_ready is high only while idle.
//   - The result is held on the out_* ports with out_valid high until the
//     consumer takes it with out_ready. The block then returns to idle.
//   - A zero divisor skips the iteration. The result is then all-ones
//     quotient, zero remainder and out_dbz set.
//
// Parameters:
//   DIVIDEND_W  unsigned dividend width
//   DIVISOR_W   unsigned divisor width
//   FRAC_W      fractional quotient bits (QUO_W = DIVIDEND_W + FRAC_W)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid / in_ready         operand handshake
//   in_dividend, in_divisor     operands
//   out_valid / out_ready       result handshake
//   out_quotient                QUO_W-bit quotient
//   out_remainder               DIVISOR_W-bit remainder
//   out_dbz                     divide-by-zero flag (qualified by out_valid)
//
// Build option:
//   FRAC_DIVIDER_EARLY_TERM_EN  When this macro is defined, the iteration stops
//                               once the partial remainder and every unconsumed
//                               numerator bit are zero. The remaining quotient
//                               bits are already zero. The results are the
//                               same with or without the macro; only the
//                               latency changes.
// -----------------------------------------------------------------------------
module frac_divider #(
  parameter int DIVIDEND_W = 10,
  parameter int DIVISOR_W  = 3,
  parameter int FRAC_W     = 10,
  localparam int QUO_W     = DIVIDEND_W + FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUO_W-1:0]      out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic                  out_dbz
);

  localparam int CNT_W = (QUO_W > 1) ? $clog2(QUO_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [QUO_W-1:0]     num;   // unconsumed numerator bits, MSB first
  logic [DIVISOR_W-1:0] dsr;   // latched divisor
  logic [DIVISOR_W:0]   rem;   // partial remainder (one guard bit)
  logic [CNT_W-1:0]     idx;   // quotient bit being resolved this cycle

  // One restoring step.
  logic [DIVISOR_W:0]   rem_sh;
  logic [DIVISOR_W:0]   rem_nxt;
  logic [QUO_W-1:0]     num_nxt;
  logic                 q_bit;
  logic                 last_bit;
  logic                 early_done;

  always_comb begin
    // After a restore the remainder is < divisor, so the shift cannot lose a
    // set bit. The guard bit keeps the compare exact.
    rem_sh   = (rem << 1) | {{DIVISOR_W{1'b0}}, num[QUO_W-1]};
    q_bit    = (rem_sh >= {1'b0, dsr});
    rem_nxt  = q_bit ? (rem_sh - {1'b0, dsr}) : rem_sh;
    num_nxt  = num << 1;
    last_bit = (idx == '0);
`ifdef FRAC_DIVIDER_EARLY_TERM_EN
    // This check uses the state after the current step. When both values are
    // zero, every later step would shift in zero and set no quotient bit.
    early_done = (rem_nxt == '0) && (num_nxt == '0);
`else
    early_done = 1'b0;
`endif
  end

  assign out_remainder = rem[DIVISOR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_dbz      <= 1'b0;
      rem          <= '0;
      num          <= '0;
      dsr          <= '0;
      idx          <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high only in IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_divisor == '0) begin
              state        <= DONE;
              out_valid    <= 1'b1;
              out_quotient <= '1;
              out_dbz      <= 1'b1;
              rem          <= '0;
            end else begin
              state        <= DIVIDE;
              dsr          <= in_divisor;
              num          <= {in_dividend, {FRAC_W{1'b0}}};
              rem          <= '0;
              out_quotient <= '0;
              out_dbz      <= 1'b0;
              idx          <= CNT_W'(QUO_W - 1);
            end
          end
        end

        DIVIDE: begin
          // The quotient was cleared on accept, so on an early exit the
          // unresolved low bits are already correct.
          out_quotient[idx] <= q_bit;
          rem               <= rem_nxt;
          num               <= num_nxt;
          idx               <= idx - 1'b1;
          if (last_bit || early_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_divider.sv
// -----------------------------------------------------------------------------
// tb_frac_divider
//
// Directed bench for frac_divider with default parameters (QUO_W = 20).
// Each vector's expected quotient, remainder and latency was worked out by
// hand. Latency counts cycles from the accepting edge: 1 means out_valid is
// high in the cycle right after the accept.
// -----------------------------------------------------------------------------
module tb_frac_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_dividend = '0;
  logic [2:0]  in_divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_quotient;
  logic [2:0]  out_remainder;
  logic        out_dbz;

  int n_tests = 0;
  int n_fail  = 0;

  frac_divider dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder),
    .out_dbz      (out_dbz)
  );

  always #5 clk = ~clk;

`ifdef FRAC_DIVIDER_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for out_valid at negedges. On entry the bench is at the negedge just
  // after the accept. Returns the observed latency in cycles.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [9:0] dvd, input logic [2:0] dsr,
                        input logic [19:0] eq, input logic [2:0] er, input logic edbz,
                        input int elat, input logic hold_rdy);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(in_ready), 64'(1));
    out_ready   = hold_rdy;
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dsr;
    @(negedge clk);
    // The operands change after the accept. The block must ignore the change.
    in_valid    = 1'b0;
    in_dividend = 10'($urandom);
    in_divisor  = 3'($urandom);
    wait_valid(lat);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " quotient"}, 64'(out_quotient), 64'(eq));
    chk({tag, " remainder"}, 64'(out_remainder), 64'(er));
    chk({tag, " dbz"}, 64'(out_dbz), 64'(edbz));
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " consumed"}, 64'(out_valid), 64'(0));
    chk({tag, " idle"}, 64'(in_ready), 64'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst quotient", 64'(out_quotient), 64'(0));
    chk("rst remainder", 64'(out_remainder), 64'(0));
    chk("rst dbz", 64'(out_dbz), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'(1));

    // Directed vectors
    run_op("10/3",   10'd10,   3'd3, 20'd3413,    3'd1, 1'b0, 21,            1'b0);
    run_op("6/3",    10'd6,    3'd3, 20'd2048,    3'd0, 1'b0, ET ? 10 : 21,  1'b0);
    run_op("1023/7", 10'd1023, 3'd7, 20'd149650,  3'd2, 1'b0, 21,            1'b0);
    run_op("1023/1", 10'd1023, 3'd1, 20'd1047552, 3'd0, 1'b0, ET ? 11 : 21,  1'b0);
    run_op("5/0",    10'd5,    3'd0, 20'hFFFFF,   3'd0, 1'b1, 1,             1'b0);
    run_op("0/5",    10'd0,    3'd5, 20'd0,       3'd0, 1'b0, ET ? 2 : 21,   1'b0);
    run_op("1/7",    10'd1,    3'd7, 20'd146,     3'd2, 1'b0, 21,            1'b0);
    // out_ready stays high from the accept onward. It must have no effect
    // before the result is ready.
    run_op("7/7rdy", 10'd7,    3'd7, 20'd1024,    3'd0, 1'b0, ET ? 11 : 21,  1'b1);

    // Hold the result with a stall while the inputs toggle.
    @(negedge clk);
    in_valid = 1'b1; in_dividend = 10'd10; in_divisor = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("stall latency", 64'(lat), 64'(21));
    for (int i = 0; i < 5; i++) begin
      in_valid    = ~in_valid;
      in_dividend = 10'($urandom);
      in_divisor  = 3'($urandom);
      @(negedge clk);
      chk("stall valid", 64'(out_valid), 64'(1));
      chk("stall in_ready", 64'(in_ready), 64'(0));
      chk("stall quotient", 64'(out_quotient), 64'(3413));
      chk("stall remainder", 64'(out_remainder), 64'(1));
      chk("stall dbz", 64'(out_dbz), 64'(0));
    end
    // The result is taken with in_valid high. No new operation may start on
    // the same edge.
    in_valid = 1'b1; in_dividend = 10'd1; in_divisor = 3'd1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("handoff valid", 64'(out_valid), 64'(0));
    chk("handoff in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("handoff no accept", 64'(in_ready), 64'(1));

    // Reset during the 8th DIVIDE cycle of 10/3.
    in_valid = 1'b1; in_dividend = 10'd10; in_divisor = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst valid", 64'(out_valid), 64'(0));
    chk("midrst quotient", 64'(out_quotient), 64'(0));
    chk("midrst remainder", 64'(out_remainder), 64'(0));
    chk("midrst dbz", 64'(out_dbz), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no result", 64'(seen), 64'(0));
    chk("midrst in_ready", 64'(in_ready), 64'(1));

    // The block still works after the aborted operation.
    run_op("post 1023/7", 10'd1023, 3'd7, 20'd149650, 3'd2, 1'b0, 21, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
